// File: rtl/vga_rect_fill_if.sv
// Command and pixel-write bundle between a rectangle requester and vga_rect_fill.
// The outline bit exists only when RECT_OUTLINE_EN is defined.
interface vga_rect_fill_if #(
   parameter string RESOLUTION              = "320x240",
   parameter int    BITS_PER_COLOUR_CHANNEL = 1,
   parameter string MONOCHROME              = "FALSE"
);
   localparam int XW = (RESOLUTION == "160x120") ? 8 : 9;
   localparam int YW = (RESOLUTION == "160x120") ? 7 : 8;
   localparam int CW = (MONOCHROME == "TRUE") ? 1 : 3*BITS_PER_COLOUR_CHANNEL;

   logic          start;
   logic [XW-1:0] x0;
   logic [YW-1:0] y0;
   logic [XW:0]   width;
   logic [YW:0]   height;
   logic [CW-1:0] colour;
   logic          stall;
   logic          ready;
   logic          done;
   logic [XW-1:0] x;
   logic [YW-1:0] y;
   logic [CW-1:0] plot_colour;
   logic          plot;
`ifdef RECT_OUTLINE_EN
   logic          outline;

   modport master (
      output start, x0, y0, width, height, colour, outline, stall,
      input  ready, done, x, y, plot_colour, plot
   );
   modport slave (
      input  start, x0, y0, width, height, colour, outline, stall,
      output ready, done, x, y, plot_colour, plot
   );
`else
   modport master (
      output start, x0, y0, width, height, colour, stall,
      input  ready, done, x, y, plot_colour, plot
   );
   modport slave (
      input  start, x0, y0, width, height, colour, stall,
      output ready, done, x, y, plot_colour, plot
   );
`endif
endinterface

// File: rtl/vga_rect_fill.sv
// Rectangle fill engine: one clipped pixel write per cycle in raster order into the VGA adapter.
// Define RECT_OUTLINE_EN to add the outline input (perimeter-only drawing).
module vga_rect_fill #(
   parameter string RESOLUTION              = "320x240",
   parameter int    BITS_PER_COLOUR_CHANNEL = 1,
   parameter string MONOCHROME              = "FALSE"
) (
   input  logic           clock,
   input  logic           resetn,
   vga_rect_fill_if.slave bus
);
   localparam int XW   = (RESOLUTION == "160x120") ? 8 : 9;
   localparam int YW   = (RESOLUTION == "160x120") ? 7 : 8;
   localparam int CW   = (MONOCHROME == "TRUE") ? 1 : 3*BITS_PER_COLOUR_CHANNEL;
   localparam int XMAX = (RESOLUTION == "160x120") ? 160 : 320;
   localparam int YMAX = (RESOLUTION == "160x120") ? 120 : 240;

   localparam logic [XW+1:0] XMAX_A = (XW+2)'(XMAX);
   localparam logic [YW+1:0] YMAX_A = (YW+2)'(YMAX);
   localparam logic [XW-1:0] XMAX_X = XW'(XMAX);
   localparam logic [YW-1:0] YMAX_Y = YW'(YMAX);

   typedef enum logic [1:0] {IDLE, CLIP, DRAW, DONE} state_t;

   state_t        r_state, w_state_nx;

   logic [XW-1:0] r_x0;
   logic [YW-1:0] r_y0;
   logic [XW:0]   r_w;
   logic [YW:0]   r_h;
   logic [CW-1:0] r_col;
   logic [XW-1:0] r_xend;
   logic [YW-1:0] r_yend;
   logic [XW-1:0] r_cx;
   logic [YW-1:0] r_cy;
   logic          r_ready;
   logic          r_done;
   logic          r_plot;

   logic [XW+1:0] w_xsum;
   logic [YW+1:0] w_ysum;
   logic [XW-1:0] w_xend;
   logic [YW-1:0] w_yend;
   logic [XW:0]   w_cx_inc;
   logic [YW:0]   w_cy_inc;
   logic          w_empty;
   logic          w_row_last;
   logic          w_col_last;
   logic          w_outline;
   logic          w_interior;
   logic          w_accept;
   logic          w_clip;
   logic          w_step;

`ifdef RECT_OUTLINE_EN
   logic          r_outline;

   always_ff @(posedge clock) begin
      if (!resetn)
         r_outline <= 1'b0;
      else if (w_accept)
         r_outline <= bus.outline;
   end

   assign w_outline = r_outline;
`else
   assign w_outline = 1'b0;
`endif

   // Clip window: extents can exceed the screen, so sums carry two spare bits
   assign w_xsum  = {2'b00, r_x0} + {1'b0, r_w};
   assign w_ysum  = {2'b00, r_y0} + {1'b0, r_h};
   assign w_xend  = (w_xsum > XMAX_A) ? XMAX_X : w_xsum[XW-1:0];
   assign w_yend  = (w_ysum > YMAX_A) ? YMAX_Y : w_ysum[YW-1:0];
   assign w_empty = (r_w == '0) || (r_h == '0) || (r_x0 >= XMAX_X) || (r_y0 >= YMAX_Y);

   assign w_cx_inc   = {1'b0, r_cx} + (XW+1)'(1);
   assign w_cy_inc   = {1'b0, r_cy} + (YW+1)'(1);
   assign w_row_last = (w_cx_inc == {1'b0, r_xend});
   assign w_col_last = (w_cy_inc == {1'b0, r_yend});
   // Interior rows of an outline only touch the left and right columns
   assign w_interior = w_outline && (r_cy != r_y0) && !w_col_last;

   always_ff @(posedge clock) begin
      if (!resetn)
         r_state <= IDLE;
      else
         r_state <= w_state_nx;
   end

   always_comb begin
      w_state_nx = r_state;
      w_accept   = 1'b0;
      w_clip     = 1'b0;
      w_step     = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (bus.start) begin
               w_accept   = 1'b1;
               w_state_nx = CLIP;
            end
         end
         CLIP: begin
            w_clip     = 1'b1;
            w_state_nx = w_empty ? DONE : DRAW;
         end
         DRAW: begin
            if (!bus.stall) begin
               if (w_row_last && w_col_last)
                  w_state_nx = DONE;
               else
                  w_step = 1'b1;
            end
         end
         DONE:    w_state_nx = IDLE;
         default: w_state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         r_ready <= 1'b1;
         r_done  <= 1'b0;
         r_plot  <= 1'b0;
         r_x0    <= '0;
         r_y0    <= '0;
         r_w     <= '0;
         r_h     <= '0;
         r_col   <= '0;
         r_xend  <= '0;
         r_yend  <= '0;
         r_cx    <= '0;
         r_cy    <= '0;
      end else begin
         r_ready <= (w_state_nx == IDLE);
         r_done  <= (w_state_nx == DONE);
         r_plot  <= (w_state_nx == DRAW);
         if (w_accept) begin
            r_x0  <= bus.x0;
            r_y0  <= bus.y0;
            r_w   <= bus.width;
            r_h   <= bus.height;
            r_col <= bus.colour;
         end
         if (w_clip) begin
            r_xend <= w_xend;
            r_yend <= w_yend;
            r_cx   <= r_x0;
            r_cy   <= r_y0;
         end
         // The final pixel leaves x/y parked on it; only earlier pixels advance
         if (w_step) begin
            if (w_row_last) begin
               r_cx <= r_x0;
               r_cy <= w_cy_inc[YW-1:0];
            end else if (w_interior) begin
               r_cx <= r_xend - XW'(1);
            end else begin
               r_cx <= w_cx_inc[XW-1:0];
            end
         end
      end
   end

   assign bus.ready       = r_ready;
   assign bus.done        = r_done;
   assign bus.plot        = r_plot;
   assign bus.x           = r_cx;
   assign bus.y           = r_cy;
   assign bus.plot_colour = r_col;
endmodule

// File: tb/tb_vga_rect_fill.sv
// Bench for vga_rect_fill: directed and random rectangles checked against a pixel-list model.
// Outline cases are exercised when RECT_OUTLINE_EN is defined.
module tb_vga_rect_fill;
   localparam int XMAX = 320;
   localparam int YMAX = 240;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   always #5 clk = ~clk;

   vga_rect_fill_if bus ();
   vga_rect_fill dut (.clock(clk), .resetn(resetn), .bus(bus));

   int errors = 0;
   int checks = 0;
   int exp_x[$];
   int exp_y[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Expected write sequence straight from the geometry: clipped raster scan,
   // optionally keeping only the perimeter of the clipped rectangle.
   task automatic build_expected(input int x0, input int y0, input int w, input int h, input bit ol);
      int xe, ye;
      exp_x.delete();
      exp_y.delete();
      if (w == 0 || h == 0 || x0 >= XMAX || y0 >= YMAX) return;
      xe = (x0 + w > XMAX) ? XMAX : x0 + w;
      ye = (y0 + h > YMAX) ? YMAX : y0 + h;
      for (int yy = y0; yy < ye; yy++)
         for (int xx = x0; xx < xe; xx++)
            if (!ol || yy == y0 || yy == ye-1 || xx == x0 || xx == xe-1) begin
               exp_x.push_back(xx);
               exp_y.push_back(yy);
            end
   endtask

   // mode: 0 no stall, 1 random stall, 2 stall 3 cycles on (1,0), 3 re-issue start mid-draw
   task automatic run_cmd(input int x0, input int y0, input int w, input int h,
                          input int col, input bit ol, input int mode);
      int  j, npix, nstall;
      bit  done_seen, exp_plot, exp_done, stl;
      logic [31:0] cv;
      cv = col;
      build_expected(x0, y0, w, h, ol);
      npix = exp_x.size();
      check("ready_idle", bus.ready, 1);
      bus.start  = 1'b1;
      bus.x0     = cv[8:0];
      bus.x0     = 9'(x0);
      bus.y0     = 8'(y0);
      bus.width  = 10'(w);
      bus.height = 9'(h);
      bus.colour = cv[2:0];
`ifdef RECT_OUTLINE_EN
      bus.outline = ol;
`endif
      step();
      bus.start  = 1'b0;
      bus.colour = cv[2:0] ^ 3'b111;
      bus.x0     = 9'($urandom_range(0, 511));
      bus.y0     = 8'($urandom_range(0, 255));
      bus.width  = 10'($urandom_range(0, 1023));
      bus.height = 9'($urandom_range(0, 511));
`ifdef RECT_OUTLINE_EN
      bus.outline = ~ol;
`endif
      j = 1;
      nstall = 0;
      done_seen = 1'b0;
      while (!done_seen && j < 3*npix + 12) begin
         exp_plot = (j >= 2) && (exp_x.size() > 0);
         exp_done = (j >= 2) && (exp_x.size() == 0);
         check("plot", bus.plot, exp_plot);
         check("done", bus.done, exp_done);
         check("ready_busy", bus.ready, 0);
         if (exp_plot) begin
            check("x", bus.x, exp_x[0]);
            check("y", bus.y, exp_y[0]);
            check("colour", bus.plot_colour, cv);
         end
         if (exp_done) begin
            done_seen = 1'b1;
         end else begin
            case (mode)
               1:       stl = ($urandom_range(0, 3) == 0);
               2:       stl = exp_plot && exp_x[0] == 1 && exp_y[0] == 0 && nstall < 3;
               default: stl = 1'b0;
            endcase
            if (mode == 3 && j == 3) begin
               bus.start  = 1'b1;
               bus.colour = cv[2:0] ^ 3'b011;
               bus.width  = 10'd1;
            end else begin
               bus.start = 1'b0;
            end
            bus.stall = stl;
            if (exp_plot && stl) nstall++;
            if (exp_plot && !stl) begin
               void'(exp_x.pop_front());
               void'(exp_y.pop_front());
            end
            step();
            j++;
         end
      end
      bus.stall = 1'b0;
      bus.start = 1'b0;
      check("done_seen", done_seen, 1);
      if (done_seen) check("latency", j, 2 + npix + nstall);
      step();
      check("ready_after", bus.ready, 1);
      check("done_pulse", bus.done, 0);
      check("plot_after", bus.plot, 0);
   endtask

   initial begin
      int rx, ry, rw, rh, rc;
      bit rol;
      bus.start  = 1'b0;
      bus.x0     = '0;
      bus.y0     = '0;
      bus.width  = '0;
      bus.height = '0;
      bus.colour = '0;
      bus.stall  = 1'b0;
`ifdef RECT_OUTLINE_EN
      bus.outline = 1'b0;
`endif
      resetn = 1'b0;
      repeat (3) step();
      check("rst_ready", bus.ready, 1);
      check("rst_done", bus.done, 0);
      check("rst_plot", bus.plot, 0);
      check("rst_x", bus.x, 0);
      check("rst_y", bus.y, 0);
      check("rst_colour", bus.plot_colour, 0);
      resetn = 1'b1;
      step();

      run_cmd(10, 20, 3, 2, 5, 1'b0, 0);
      run_cmd(318, 239, 5, 4, 3, 1'b0, 0);
      run_cmd(30, 40, 0, 7, 2, 1'b0, 0);
      run_cmd(320, 10, 4, 4, 1, 1'b0, 0);
      run_cmd(0, 0, 2, 2, 4, 1'b0, 2);
      run_cmd(50, 60, 6, 4, 7, 1'b0, 3);
`ifdef RECT_OUTLINE_EN
      run_cmd(0, 0, 4, 3, 2, 1'b1, 0);
      run_cmd(100, 100, 1, 5, 3, 1'b1, 1);
      run_cmd(315, 236, 10, 10, 5, 1'b1, 1);
`endif

      // Reset while drawing abandons the command
      bus.start  = 1'b1;
      bus.x0     = 9'd5;
      bus.y0     = 8'd5;
      bus.width  = 10'd10;
      bus.height = 9'd10;
      bus.colour = 3'd6;
      step();
      bus.start = 1'b0;
      repeat (3) step();
      check("mid_plot", bus.plot, 1);
      resetn = 1'b0;
      step();
      resetn = 1'b1;
      check("mrst_plot", bus.plot, 0);
      check("mrst_ready", bus.ready, 1);
      check("mrst_done", bus.done, 0);
      check("mrst_x", bus.x, 0);
      check("mrst_y", bus.y, 0);
      check("mrst_colour", bus.plot_colour, 0);
      for (int k = 0; k < 5; k++) begin
         step();
         check("mrst_quiet_done", bus.done, 0);
         check("mrst_quiet_plot", bus.plot, 0);
      end

      for (int n = 0; n < 20; n++) begin
         rx  = $urandom_range(0, 335);
         ry  = $urandom_range(0, 250);
         rw  = $urandom_range(0, 20);
         rh  = $urandom_range(0, 12);
         rc  = $urandom_range(0, 7);
         rol = 1'b0;
`ifdef RECT_OUTLINE_EN
         rol = 1'($urandom_range(0, 1));
`endif
         run_cmd(rx, ry, rw, rh, rc, rol, 1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
